// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : voice_allocator
//  Purpose  : Assigns note-on/note-off events to NBANKS voice slots and walks
//             the slots round-robin (one per clk_en) so the phase bank sees
//             voice k's MIDI note in the same clk_en cycle it processes bank k.
//             Note value 0 marks a silent slot.
//  Options  : VOICE_STEAL_EN - when defined, a note-on with no free slot
//             overwrites the slot at a rotating steal pointer instead of
//             being dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int NBANKS = 10,
    parameter int SW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          i_ev_valid,
    output logic          o_ev_ready,
    input  logic          i_ev_on,
    input  logic [6:0]    i_ev_note,
    output logic [6:0]    o_midi,
    output logic [SW-1:0] o_slot,
    output logic [SW-1:0] o_active_cnt,
    output logic          o_steal,
    output logic          o_drop
);

    localparam logic [SW-1:0] c_LAST = SW'(NBANKS - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_COMMIT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [6:0]      r_table [NBANKS];
    logic            r_ev_on;
    logic [6:0]      r_ev_note;

    logic            w_latch;
    logic            w_wr_en;
    logic [SW-1:0]   w_wr_idx;
    logic [6:0]      w_wr_data;
    logic            w_inc;
    logic            w_dec;
    logic            w_steal;
    logic            w_drop;

    logic            w_match_found;
    logic [SW-1:0]   w_match_idx;
    logic            w_free_found;
    logic [SW-1:0]   w_free_idx;

    logic [SW-1:0]   w_next_slot;
    logic [6:0]      w_next_midi;

`ifdef VOICE_STEAL_EN
    logic [SW-1:0]   r_steal_ptr;
    logic            w_steal_adv;
`endif

    // Lowest-index slot holding the latched note, and lowest-index free slot.
    // Scanning downward lets the last hit (the lowest index) win.
    always_comb begin
        w_match_found = 1'b0;
        w_match_idx   = '0;
        w_free_found  = 1'b0;
        w_free_idx    = '0;
        for (int i = NBANKS - 1; i >= 0; i--) begin
            if (r_table[i] == r_ev_note) begin
                w_match_found = 1'b1;
                w_match_idx   = i[SW-1:0];
            end
            if (r_table[i] == 7'd0) begin
                w_free_found = 1'b1;
                w_free_idx   = i[SW-1:0];
            end
        end
    end

    // FSM next state plus event resolution; writes happen only in COMMIT.
    always_comb begin
        w_next_state = r_state;
        o_ev_ready   = 1'b0;
        w_latch      = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_idx     = '0;
        w_wr_data    = 7'd0;
        w_inc        = 1'b0;
        w_dec        = 1'b0;
        w_steal      = 1'b0;
        w_drop       = 1'b0;
`ifdef VOICE_STEAL_EN
        w_steal_adv  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                o_ev_ready = 1'b1;
                if (i_ev_valid) begin
                    w_latch      = 1'b1;
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_next_state = S_IDLE;
                if (r_ev_on) begin
                    if (r_ev_note == 7'd0) begin
                        w_drop = 1'b1;
                    end else if (w_match_found) begin
                        // Retrigger of a sounding note: table left alone.
                        w_drop = 1'b0;
                    end else if (w_free_found) begin
                        w_wr_en   = 1'b1;
                        w_wr_idx  = w_free_idx;
                        w_wr_data = r_ev_note;
                        w_inc     = 1'b1;
                    end else begin
`ifdef VOICE_STEAL_EN
                        w_wr_en     = 1'b1;
                        w_wr_idx    = r_steal_ptr;
                        w_wr_data   = r_ev_note;
                        w_steal     = 1'b1;
                        w_steal_adv = 1'b1;
`else
                        w_drop = 1'b1;
`endif
                    end
                end else begin
                    // Note-off of 0 would match a silent slot; ignore it.
                    if ((r_ev_note != 7'd0) && w_match_found) begin
                        w_wr_en   = 1'b1;
                        w_wr_idx  = w_match_idx;
                        w_wr_data = 7'd0;
                        w_dec     = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the accepted event for resolution in the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ev_on   <= 1'b0;
            r_ev_note <= 7'd0;
        end else if (w_latch) begin
            r_ev_on   <= i_ev_on;
            r_ev_note <= i_ev_note;
        end
    end

    // Voice slot table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBANKS; i++) begin
                r_table[i] <= 7'd0;
            end
        end else begin
            for (int i = 0; i < NBANKS; i++) begin
                if (w_wr_en && (w_wr_idx == i[SW-1:0])) begin
                    r_table[i] <= w_wr_data;
                end
            end
        end
    end

    // Active-voice count tracks fills and clears; a steal keeps it constant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_active_cnt <= '0;
        end else if (w_inc) begin
            o_active_cnt <= o_active_cnt + SW'(1);
        end else if (w_dec) begin
            o_active_cnt <= o_active_cnt - SW'(1);
        end
    end

    // One-cycle status pulses following COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_steal <= 1'b0;
            o_drop  <= 1'b0;
        end else begin
            o_steal <= w_steal;
            o_drop  <= w_drop;
        end
    end

`ifdef VOICE_STEAL_EN
    // Rotating victim pointer, advanced after each steal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_steal_ptr <= '0;
        end else if (w_steal_adv) begin
            r_steal_ptr <= (r_steal_ptr == c_LAST) ? '0 : r_steal_ptr + SW'(1);
        end
    end
`endif

    // Next slot of the walk and its note, forwarding a same-cycle write.
    always_comb begin
        w_next_slot = (o_slot == c_LAST) ? '0 : o_slot + SW'(1);
        w_next_midi = 7'd0;
        for (int i = 0; i < NBANKS; i++) begin
            if (w_next_slot == i[SW-1:0]) begin
                w_next_midi = r_table[i];
            end
        end
        if (w_wr_en && (w_wr_idx == w_next_slot)) begin
            w_next_midi = w_wr_data;
        end
    end

    // Round-robin slot walk; starts at NBANKS-1 so the first clk_en shows slot 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_slot <= c_LAST;
            o_midi <= 7'd0;
        end else if (clk_en) begin
            o_slot <= w_next_slot;
            o_midi <= w_next_midi;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_voice_allocator
//  Purpose  : Self-checking bench for voice_allocator against a slot-table
//             reference model. Define VOICE_STEAL_EN to match the DUT build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    localparam int NBANKS = 10;
    localparam int SW     = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clk_en = 1'b0;
    logic          i_ev_valid = 1'b0;
    logic          o_ev_ready;
    logic          i_ev_on = 1'b0;
    logic [6:0]    i_ev_note = 7'd0;
    logic [6:0]    o_midi;
    logic [SW-1:0] o_slot;
    logic [SW-1:0] o_active_cnt;
    logic          o_steal;
    logic          o_drop;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_tab [NBANKS];
    int m_slot;
    int m_midi;
    bit m_busy;
    bit m_on;
    int m_note;
    int m_sp;
    bit m_steal;
    bit m_drop;

    voice_allocator #(.NBANKS(NBANKS), .SW(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .i_ev_valid   (i_ev_valid),
        .o_ev_ready   (o_ev_ready),
        .i_ev_on      (i_ev_on),
        .i_ev_note    (i_ev_note),
        .o_midi       (o_midi),
        .o_slot       (o_slot),
        .o_active_cnt (o_active_cnt),
        .o_steal      (o_steal),
        .o_drop       (o_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        assert (act === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int count_active();
        int c = 0;
        for (int i = 0; i < NBANKS; i++) if (m_tab[i] != 0) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NBANKS; i++) m_tab[i] = 0;
        m_slot = NBANKS - 1;
        m_midi = 0;
        m_busy = 0;
        m_on = 0;
        m_note = 0;
        m_sp = 0;
        m_steal = 0;
        m_drop = 0;
    endtask

    // Resolve a latched event against the table by the allocation rules.
    task automatic model_apply();
        int hit;
        int fr;
        hit = -1;
        fr = -1;
        for (int i = NBANKS - 1; i >= 0; i--) begin
            if (m_tab[i] == m_note) hit = i;
            if (m_tab[i] == 0) fr = i;
        end
        if (m_on) begin
            if (m_note == 0) m_drop = 1;
            else if (hit >= 0) begin end
            else if (fr >= 0) m_tab[fr] = m_note;
            else begin
`ifdef VOICE_STEAL_EN
                m_tab[m_sp] = m_note;
                m_steal = 1;
                m_sp = (m_sp + 1) % NBANKS;
`else
                m_drop = 1;
`endif
            end
        end else if (m_note != 0 && hit >= 0) begin
            m_tab[hit] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".slot"},   int'(o_slot), m_slot);
        chk({tag, ".midi"},   int'(o_midi), m_midi);
        chk({tag, ".ready"},  int'(o_ev_ready), int'(!m_busy));
        chk({tag, ".cnt"},    int'(o_active_cnt), count_active());
        chk({tag, ".steal"},  int'(o_steal), int'(m_steal));
        chk({tag, ".drop"},   int'(o_drop), int'(m_drop));
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, compare.
    task automatic step(input string tag, input bit en, input bit v, input bit on, input int note);
        clk_en = en;
        i_ev_valid = v;
        i_ev_on = on;
        i_ev_note = note[6:0];
        @(posedge clk);
        m_steal = 0;
        m_drop = 0;
        if (m_busy) begin
            model_apply();
            m_busy = 0;
        end else if (v) begin
            m_busy = 1;
            m_on = on;
            m_note = note;
        end
        if (en) begin
            m_slot = (m_slot == NBANKS - 1) ? 0 : m_slot + 1;
            m_midi = m_tab[m_slot];
        end
        #1;
        check_all(tag);
    endtask

    // Issue one event followed by its COMMIT cycle.
    task automatic event2(input string tag, input bit en, input bit on, input int note);
        step(tag, en, 1'b1, on, note);
        step(tag, en, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clk_en = 0;
        i_ev_valid = 0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Walk after reset with no voices
        for (int k = 0; k < NBANKS + 1; k++) step("walk", 1'b1, 1'b0, 1'b0, 0);

        // Basic allocation and clearing
        event2("on45", 1'b1, 1'b1, 'h45);
        event2("on30", 1'b1, 1'b1, 'h30);
        for (int k = 0; k < NBANKS; k++) step("walk2", 1'b1, 1'b0, 1'b0, 0);
        event2("off45", 1'b0, 1'b0, 'h45);
        event2("on50", 1'b1, 1'b1, 'h50);
        event2("off22", 1'b1, 1'b0, 'h22);
        event2("retrig", 1'b1, 1'b1, 'h50);

        // Fill table and overflow
        do_reset();
        for (int k = 0; k < NBANKS; k++) event2("fill", k[0], 1'b1, 'h3C + k);
        event2("over60", 1'b1, 1'b1, 'h60);
        event2("over61", 1'b1, 1'b1, 'h61);
        for (int k = 0; k < NBANKS; k++) step("walk3", 1'b1, 1'b0, 1'b0, 0);

        // Forwarding: commit lands while the walk loads slot 3
        do_reset();
        for (int k = 0; k < 3; k++) event2("pre", 1'b0, 1'b1, 'h20 + k);
        for (int k = 0; k < 2 * NBANKS && m_slot != 1; k++) step("align", 1'b1, 1'b0, 1'b0, 0);
        chk("align.slot", int'(o_slot), 1);
        step("fwd", 1'b1, 1'b1, 1'b1, 'h40);
        step("fwd", 1'b1, 1'b0, 1'b0, 0);
        chk("fwd.midi40", int'(o_midi), 'h40);
        event2("on00", 1'b1, 1'b1, 'h00);

        // Reset during COMMIT with clk_en toggling
        step("pre_rst", 1'b1, 1'b1, 1'b1, 'h55);
        clk_en = 1'b1;
        #2;
        rst = 1;
        #1;
        model_reset();
        check_all("rst_commit");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            clk_en = k[0];
        end
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst = 0;
        step("post_rst", 1'b1, 1'b0, 1'b0, 0);
        chk("post_rst.slot0", int'(o_slot), 0);

        // Randomized traffic from a small note pool to force hits and overflow
        for (int k = 0; k < 600; k++) begin
            int nt;
            nt = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range('h30, 'h3D));
            step("rand", bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) != 0),
                 bit'($urandom_range(0, 2) != 0), nt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
